// File: rtl/slt_cmp_iter_if.sv
// Request/result bundle between decode and the iterative compare unit.
// No logic inside; latency is set by whichever module drives it.
// Valid/ready on both sides: request in_vld/in_rdy, result out_vld/out_rdy.
interface slt_cmp_iter_if #(
  parameter int XLEN = 32
);
  logic            in_vld;
  logic            in_rdy;
  logic            is_branch;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1_dat;
  logic [XLEN-1:0] rs2_dat;
  logic            out_vld;
  logic            out_rdy;
  logic [XLEN-1:0] out_dat;
  logic            taken;

  // Producer/consumer side (decode + writeback/PC-select)
  modport master (
    output in_vld, is_branch, func3, rs1_dat, rs2_dat, out_rdy,
    input  in_rdy, out_vld, out_dat, taken
  );

  // Compare unit side
  modport slave (
    input  in_vld, is_branch, func3, rs1_dat, rs2_dat, out_rdy,
    output in_rdy, out_vld, out_dat, taken
  );
endinterface

// File: rtl/slt_cmp_iter.sv
// Iterative SLT/SLTU and branch compare, CHUNK bits per cycle, MSB chunk first.
// Result valid k cycles after accept (k = deciding chunk, 1..N; N when EARLY_EXIT=0).
// in_rdy only in IDLE; result held in DONE until out_rdy; flush aborts to IDLE.
module slt_cmp_iter #(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  slt_cmp_iter_if.slave bus
);
  localparam int N  = XLEN / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > XLEN) || ((XLEN % CHUNK) != 0)) begin : g_bad_param
      $error("slt_cmp_iter: XLEN must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      func3_q;
  logic            br_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            taken_q, taken_d;
  logic            cap;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic             signed_op;
  logic             diff;
  logic             res_out;
  logic             res_taken;

  // Select the current chunk; signed ops bias the sign bit in the top chunk so an unsigned compare works
  always_comb begin
    signed_op = br_q ? ((func3_q == 3'b100) || (func3_q == 3'b101)) : (func3_q == 3'b010);
    a_ch      = a_q[idx_q*CHUNK +: CHUNK];
    b_ch      = b_q[idx_q*CHUNK +: CHUNK];
    if (signed_op && (idx_q == IDX_TOP)) begin
      a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
      b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
    end
    diff = (a_ch != b_ch);
  end

  // Next state, compare accumulation and result decode; flush overrides everything
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    out_d     = out_q;
    taken_d   = taken_q;
    cap       = 1'b0;
    res_out   = 1'b0;
    res_taken = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_vld) begin
          cap     = 1'b1;
          state_d = S_CMP;
          idx_d   = IDX_TOP;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
        end
      end
      S_CMP: begin
        // Only the first unequal chunk decides lt
        if (diff && eq_q) begin
          eq_d = 1'b0;
          lt_d = (a_ch < b_ch);
        end
        if ((idx_q == '0) || (EARLY_EXIT && diff)) begin
          state_d = S_DONE;
          if (!br_q) begin
            res_out = ((func3_q == 3'b010) || (func3_q == 3'b011)) ? lt_d : 1'b0;
          end else begin
            case (func3_q)
              3'b000:  res_taken = eq_d;
              3'b001:  res_taken = ~eq_d;
              3'b100:  res_taken = lt_d;
              3'b101:  res_taken = ~lt_d;
              3'b110:  res_taken = lt_d;
              3'b111:  res_taken = ~lt_d;
              default: res_taken = 1'b0;
            endcase
          end
          out_d   = XLEN'(res_out);
          taken_d = res_taken;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      cap     = 1'b0;
      out_d   = out_q;
      taken_d = taken_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept plus compare/result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      func3_q <= '0;
      br_q    <= 1'b0;
      idx_q   <= '0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      out_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      if (cap) begin
        a_q     <= bus.rs1_dat;
        b_q     <= bus.rs2_dat;
        func3_q <= bus.func3;
        br_q    <= bus.is_branch;
      end
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      out_q   <= out_d;
      taken_q <= taken_d;
    end
  end

  assign bus.in_rdy  = (state_q == S_IDLE);
  assign bus.out_vld = (state_q == S_DONE);
  assign bus.out_dat = out_q;
  assign bus.taken   = taken_q;
endmodule

// File: tb/tb_slt_cmp_iter.sv
// Scoreboard bench for slt_cmp_iter: one early-exit and one full-scan instance.
// Expected results come from a whole-word reference model at issue time.
// Checks result values, latency, hold under out_rdy=0, async reset and flush.
module tb_slt_cmp_iter;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        sel;
  logic        d_vld;
  logic        d_br;
  logic [2:0]  d_f3;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic        d_ordy;

  int n_chk;
  int n_bad;

  typedef struct {
    logic [31:0] out;
    logic        taken;
    int          k;
  } exp_t;

  exp_t exp_q[$];

  slt_cmp_iter_if #(.XLEN(32)) if0 ();
  slt_cmp_iter_if #(.XLEN(32)) if1 ();

  assign if0.in_vld    = d_vld & ~sel;
  assign if1.in_vld    = d_vld & sel;
  assign if0.is_branch = d_br;
  assign if1.is_branch = d_br;
  assign if0.func3     = d_f3;
  assign if1.func3     = d_f3;
  assign if0.rs1_dat   = d_a;
  assign if1.rs1_dat   = d_a;
  assign if0.rs2_dat   = d_b;
  assign if1.rs2_dat   = d_b;
  assign if0.out_rdy   = d_ordy & ~sel;
  assign if1.out_rdy   = d_ordy & sel;

  wire        o_rdy = sel ? if1.in_rdy  : if0.in_rdy;
  wire        o_vld = sel ? if1.out_vld : if0.out_vld;
  wire [31:0] o_out = sel ? if1.out_dat : if0.out_dat;
  wire        o_tkn = sel ? if1.taken   : if0.taken;

  slt_cmp_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_ee (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (if0.slave)
  );

  slt_cmp_iter #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_full (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit br, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] b, input bit ee);
    exp_t e;
    bit lt_s, lt_u, eq, found;
    bit [31:0] d;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    e.out   = 32'd0;
    e.taken = 1'b0;
    if (!br) begin
      if (f3 == 3'b010) e.out = {31'd0, lt_s};
      if (f3 == 3'b011) e.out = {31'd0, lt_u};
    end else begin
      case (f3)
        3'b000:  e.taken = eq;
        3'b001:  e.taken = !eq;
        3'b100:  e.taken = lt_s;
        3'b101:  e.taken = !lt_s;
        3'b110:  e.taken = lt_u;
        3'b111:  e.taken = !lt_u;
        default: e.taken = 1'b0;
      endcase
    end
    e.k   = 4;
    found = 1'b0;
    d     = a ^ b;
    if (ee) begin
      for (int i = 3; i >= 0; i--) begin
        if (!found && (d[i*8 +: 8] != 8'd0)) begin
          e.k   = 4 - i;
          found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Present a request, wait for acceptance, push the expected result
  task automatic start(input bit br, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
    int w;
    @(negedge clk);
    d_br  = br;
    d_f3  = f3;
    d_a   = a;
    d_b   = b;
    d_vld = 1'b1;
    w = 0;
    while (!o_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!o_rdy) chk("accept_wait", {31'd0, o_rdy}, 32'd1);
    @(posedge clk);
    exp_q.push_back(model(br, f3, a, b, !sel));
    @(negedge clk);
    d_vld = 1'b0;
    d_a   = $urandom;
    d_b   = $urandom;
    chk("busy_rdy", {31'd0, o_rdy}, 32'd0);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then drain
  task automatic finish(input string tag, input int hold);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!o_vld && cyc < 20);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_lat"}, cyc, e.k);
    chk({tag, "_out"}, o_out, e.out);
    chk({tag, "_tkn"}, {31'd0, o_tkn}, {31'd0, e.taken});
    chk({tag, "_rdy"}, {31'd0, o_rdy}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, {31'd0, o_vld}, 32'd1);
      chk({tag, "_hold_out"}, o_out, e.out);
      chk({tag, "_hold_tkn"}, {31'd0, o_tkn}, {31'd0, e.taken});
      chk({tag, "_hold_rdy"}, {31'd0, o_rdy}, 32'd0);
    end
    d_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_ordy = 1'b0;
    chk({tag, "_drain_vld"}, {31'd0, o_vld}, 32'd0);
    chk({tag, "_drain_rdy"}, {31'd0, o_rdy}, 32'd1);
  endtask

  initial begin
    exp_t    dump;
    bit      rb;
    bit [2:0] rf;
    bit [31:0] ra, rbv;
    n_chk  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    sel    = 1'b0;
    d_vld  = 1'b0;
    d_br   = 1'b0;
    d_f3   = 3'b000;
    d_a    = 32'd0;
    d_b    = 32'd0;
    d_ordy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_rdy", {31'd0, o_rdy}, 32'd1);
      chk("rst_vld", {31'd0, o_vld}, 32'd0);
      chk("rst_out", o_out, 32'd0);
      chk("rst_tkn", {31'd0, o_tkn}, 32'd0);
    end
    sel = 1'b0;

    start(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h1);    finish("slt_m1_1", 0);
    start(1'b0, 3'b011, 32'hFFFF_FFFF, 32'h1);    finish("sltu_max_1", 0);
    start(1'b0, 3'b011, 32'h0000_0100, 32'h101);  finish("sltu_low", 0);

    // Async reset between edges in the middle of an op, with OUT=1 left from the previous op
    start(1'b0, 3'b011, 32'h0000_0100, 32'h101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, o_vld}, 32'd0);
    chk("arst_out", o_out, 32'd0);
    chk("arst_rdy", {31'd0, o_rdy}, 32'd1);
    dump = exp_q.pop_front();
    @(negedge clk);
    rst_n = 1'b1;

    // Flush before the deciding edge: no result, OUT keeps its reset value
    start(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    dump = exp_q.pop_front();
    chk("flush_rdy", {31'd0, o_rdy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_vld", {31'd0, o_vld}, 32'd0);
      chk("flush_out", o_out, 32'd0);
    end

    start(1'b1, 3'b000, 32'h1234_5678, 32'h1234_5678);  finish("beq_eq", 5);
    start(1'b1, 3'b111, 32'h1234_5678, 32'h1234_5678);  finish("bgeu_eq", 0);
    start(1'b1, 3'b100, 32'hFFFF_FFFB, 32'h3);          finish("blt_ee", 0);
    start(1'b1, 3'b010, 32'h1, 32'h2);                  finish("br_rsvd", 0);

    sel = 1'b1;
    start(1'b1, 3'b100, 32'hFFFF_FFFB, 32'h3);          finish("blt_full", 0);
    start(1'b0, 3'b000, 32'h5, 32'h9);                  finish("op000_full", 0);
    start(1'b0, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF);  finish("slt_min_full", 2);

    for (int i = 0; i < 24; i++) begin
      sel = i[0];
      rb  = $urandom_range(0, 1);
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case (i % 3)
        0:       rbv = $urandom;
        1:       rbv = ra;
        default: rbv = ra ^ (32'h1 << $urandom_range(0, 31));
      endcase
      start(rb, rf, ra, rbv);
      finish("rnd", 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
